// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared FSM state type and constants for the APB slave register bank.
package apb_slv_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} apb_state_t;
    localparam logic [31:0] ID_DEFAULT = 32'hA2B0_0001;
    localparam logic [7:0] ERR_SAT = 8'hFF;
endpackage

// File: rtl/apb_slv_decode.sv
// apb_slv_decode: maps an APB byte address to a word index and flags misaligned or out-of-window addresses.
module apb_slv_decode #(
    parameter int NREGS = 16
) (
    input  logic [31:0]              Paddr,
    output logic [$clog2(NREGS)-1:0] idx,
    output logic                     dec_err
);
    localparam int AW = $clog2(NREGS);
    logic unused_hi;
    // Bits above 25 belong to the bridge's peripheral decode and are ignored here.
    assign unused_hi = ^Paddr[31:26];
    assign idx = Paddr[AW+1:2];
    assign dec_err = (|Paddr[1:0]) | (|Paddr[25:AW+2]);
endmodule

// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB slave register file with registered read data and a one-cycle error pulse.
// APB_SLV_ERRCNT_EN adds a saturating protocol error counter readable in the last register.
module apb_slave_regbank
    import apb_slv_pkg::*;
#(
    parameter int          NREGS    = 16,
    parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
`ifdef APB_SLV_ERRCNT_EN
    output logic [7:0]  err_count,
`endif
    output logic        Pslverr
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
    apb_state_t state, state_next;
    logic [31:0] lat_addr;
    logic lat_write;
    logic [31:0] regs [NREGS];
    logic [AW-1:0] idx;
    logic dec_err, setup_go, access_ok, proto_err, err_pulse, wr_en;
    logic [31:0] rd_val;

    apb_slv_decode #(.NREGS(NREGS)) u_decode (
        .Paddr  (Paddr),
        .idx    (idx),
        .dec_err(dec_err)
    );

    always_comb begin
        setup_go   = Psel & ~Penable & (state != ST_SETUP);
        // The access phase must repeat exactly the address and direction seen in setup.
        access_ok  = (state == ST_SETUP) & Psel & Penable & (Paddr == lat_addr) & (Pwrite == lat_write);
        proto_err  = ((state == ST_IDLE) & Psel & Penable) | ((state == ST_SETUP) & ~access_ok) |
                     ((state == ST_ACCESS) & Psel & Penable);
        err_pulse  = proto_err | (access_ok & dec_err);
        wr_en      = access_ok & lat_write & ~dec_err;
        state_next = setup_go ? ST_SETUP : access_ok ? ST_ACCESS : ST_IDLE;
`ifdef APB_SLV_ERRCNT_EN
        rd_val = dec_err ? 32'h0 : (idx == '0) ? ID_VALUE : (idx == LAST) ? {24'h0, err_count} : regs[idx];
`else
        rd_val = dec_err ? 32'h0 : (idx == '0) ? ID_VALUE : regs[idx];
`endif
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state     <= ST_IDLE;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            Prdata    <= '0;
            Pslverr   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef APB_SLV_ERRCNT_EN
            err_count <= '0;
`endif
        end else begin
            state   <= state_next;
            Pslverr <= err_pulse;
            if (setup_go) begin
                lat_addr  <= Paddr;
                lat_write <= Pwrite;
                if (!Pwrite) Prdata <= rd_val;
            end
`ifdef APB_SLV_ERRCNT_EN
            if (wr_en && idx != '0 && idx != LAST) regs[idx] <= Pwdata;
            if (wr_en && idx == LAST) err_count <= '0;
            else if (err_pulse && err_count != ERR_SAT) err_count <= err_count + 8'd1;
`else
            if (wr_en && idx != '0) regs[idx] <= Pwdata;
`endif
        end
    end
endmodule

// File: doc/apb_slave_regbank.md
# apb_slave_regbank

APB slave register bank that sits directly downstream of the AHB-to-APB bridge, on one bit of its 3-bit peripheral select. It tracks the APB setup/access phases and commits writes into a small register file. It returns registered read data valid throughout the access phase, so the bridge's pass-through read path sees stable data. Protocol violations are flagged on a one-cycle error pulse.

## Interface
Parameters:
- NREGS, 16: number of 32-bit registers; power of 2, 4..64.
- ID_VALUE, 32'hA2B0_0001: read-only contents of register 0.

Ports:
- Hclk  in  1  the single clock; every flop is on its rising edge.
- Hreset  in  1  reset, asynchronous and active-high; all state clears immediately on assertion.
- Psel  in  1  this slave's select; one bit of the bridge's Pselx.
- Penable  in  1  APB enable; marks the access phase.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  byte address; the word index is Paddr[log2(NREGS)+1:2].
- Pwdata  in  32  write data.
- Prdata  out  32  registered read data.
- Pslverr  out  1  one-cycle protocol/decode error pulse.
- err_count  out  8  protocol error count; present only with APB_SLV_ERRCNT_EN.

## Operation
- FSM states: ST_IDLE, ST_SETUP, ST_ACCESS; reset state is ST_IDLE.
- ST_IDLE:
  - Psel & ~Penable -> ST_SETUP; latch Paddr and Pwrite.
  - Psel & Penable -> protocol error; stay in ST_IDLE.
- ST_SETUP:
  - Psel & Penable, with Paddr/Pwrite equal to the latched values -> ST_ACCESS.
  - Any other input, or a changed address/direction -> protocol error; go to ST_IDLE.
- ST_ACCESS:
  - Psel & ~Penable -> ST_SETUP (back-to-back transfer; latch new Paddr/Pwrite).
  - ~Psel -> ST_IDLE.
  - Psel & Penable -> protocol error (enable held two cycles); go to ST_IDLE.
- Decode error: Paddr[1:0] != 0, or Paddr[25:log2(NREGS)+2] != 0. A decode error is reported on the access edge and the access is suppressed.
- Read: on the ST_IDLE/ST_ACCESS -> ST_SETUP edge with Pwrite=0, Prdata loads the addressed register. On any other edge Prdata holds its value; it is never zeroed between reads. Decode-error reads return 32'h0.
- Write: committed on the ST_SETUP -> ST_ACCESS edge when Pwrite=1 and there is no decode error.
  - Register 0 ignores writes; this is not an error.
  - Registers 1..NREGS-1 are read/write and reset to 0.
- Errors never corrupt registers: a write that errors is dropped.

## Timing
- Reset values: Prdata = 0, Pslverr = 0, err_count = 0, registers 1..N-1 = 0, FSM in ST_IDLE.
- Read latency: Prdata is valid from the first edge after setup and stays stable for the whole access cycle and beyond.
- Write visibility: a read issued in the setup immediately following the write's access returns the new data.
- Pslverr is asserted for exactly one cycle, on the edge after the violation is detected.
- Reset asserted mid-transfer: any in-flight write is discarded and the FSM returns to ST_IDLE. After release, the first valid setup is accepted normally.

## Configuration
- APB_SLV_ERRCNT_EN defined:
  - err_count increments on every Pslverr pulse and saturates at 8'hFF.
  - Register NREGS-1 becomes read-only and returns {24'h0, err_count}.
  - A write of any value to register NREGS-1 clears the counter.
- APB_SLV_ERRCNT_EN undefined:
  - The err_count port and counter are absent.
  - Register NREGS-1 is an ordinary read/write register.

## Structure
- Shared package apb_slv_pkg holds the apb_state_t enum (ST_IDLE/ST_SETUP/ST_ACCESS), the default ID_VALUE, and the 8'hFF saturation constant.
- One sub-module, apb_slv_decode: combinational; takes Paddr and produces the word index and the decode-error flag.
- The FSM, register file and error counter stay in the top module.

## Test plan
- Reset, then read register 0 (Paddr 32'h8000_0000) -> Prdata = 32'hA2B0_0001 during access; Pslverr stays 0.
- Write 32'hDEAD_BEEF to Paddr 32'h8000_0008, then read it back-to-back -> Prdata = 32'hDEAD_BEEF; write 32'h1 to register 0 -> reads still return the ID.
- Psel & Penable from ST_IDLE -> one-cycle Pslverr; err_count = 1 (macro on); registers unchanged.
- Paddr 32'h8000_0102 (misaligned) write 32'h5 -> Pslverr pulse; a subsequent read of the index shows the old value.
- Assert Hreset between setup and access of a write of 32'h1234 to register 2 -> register 2 reads 0 after reset release.
- With macro on: 300 protocol errors -> err_count = 8'hFF; write to register NREGS-1 -> err_count = 0.
